// File: rtl/clause_lits_n_if.sv
// Bus between one clause literal slot and the variable base / bin controller.
// The slot itself connects through the slave modport.
interface clause_lits_n_if #(
  parameter int NUM_LITS = 8
);
  logic                    wr_i;
  logic [2*NUM_LITS-1:0]   lit_pol_i;
  logic [3*NUM_LITS-1:0]   var_value_frombase_i;
  logic [3*NUM_LITS-1:0]   var_value_tobase_o;
  logic [1:0]              freelitcnt_o;
  logic                    clausesat_o;
  logic                    unit_o;
  logic                    conflict_o;
  logic                    imp_drv_i;
  logic                    imp_valid_o;
  logic                    imp_ack_i;
  logic                    cclause_drv_i;
  logic [NUM_LITS-1:0]     cclause_o;

  modport master (
    output wr_i, lit_pol_i, var_value_frombase_i, imp_drv_i, imp_ack_i, cclause_drv_i,
    input  var_value_tobase_o, freelitcnt_o, clausesat_o, unit_o, conflict_o,
           imp_valid_o, cclause_o
  );

  modport slave (
    input  wr_i, lit_pol_i, var_value_frombase_i, imp_drv_i, imp_ack_i, cclause_drv_i,
    output var_value_tobase_o, freelitcnt_o, clausesat_o, unit_o, conflict_o,
           imp_valid_o, cclause_o
  );
endinterface

// File: rtl/clause_lits_n.sv
// One clause slot of a SAT bin: literal polarity store, registered sat/unit/conflict
// status, and a small FSM that drives implications or exposes the conflict mask.
module clause_lits_n #(
  parameter int NUM_LITS = 8
) (
  input  logic           clk,
  input  logic           rst,
  clause_lits_n_if.slave bus
);
  localparam int IDX_W = (NUM_LITS > 1) ? $clog2(NUM_LITS) : 1;
  localparam int CNT_W = $clog2(NUM_LITS + 1);

  typedef enum logic [1:0] {IDLE, IMPLY, CONFL} state_t;

  function automatic logic [1:0] sat_cnt(input logic [CNT_W-1:0] n);
    return (n > CNT_W'(3)) ? 2'd3 : n[1:0];
  endfunction

  logic [2*NUM_LITS-1:0] pol;
  logic [NUM_LITS-1:0]   present, lit_true, lit_free;
  logic [CNT_W-1:0]      free_cnt;
  logic [IDX_W-1:0]      first_idx;

  logic       sat_r, unit_r, conflict_r;
  logic [1:0] cnt_r;

  state_t              state, state_nx;
  logic [IDX_W-1:0]    idx_r, idx_nx;
  logic [1:0]          val_r, val_nx;
  logic [NUM_LITS-1:0] mask_r, mask_nx;

  // Stage 0: combinational literal evaluation against the base values.
  always_comb begin
    present   = '0;
    lit_true  = '0;
    lit_free  = '0;
    free_cnt  = '0;
    first_idx = '0;
    for (int j = 0; j < NUM_LITS; j++) begin
      present[j]  = (pol[2*j +: 2] == 2'b01) || (pol[2*j +: 2] == 2'b10);
      lit_true[j] = ((pol[2*j +: 2] == 2'b01) && (bus.var_value_frombase_i[3*j +: 2] == 2'b01)) ||
                    ((pol[2*j +: 2] == 2'b10) && (bus.var_value_frombase_i[3*j +: 2] == 2'b10));
      lit_free[j] = present[j] && ((bus.var_value_frombase_i[3*j +: 2] == 2'b00) ||
                                   (bus.var_value_frombase_i[3*j +: 2] == 2'b11));
      free_cnt    = free_cnt + CNT_W'(lit_free[j]);
    end
    for (int j = NUM_LITS - 1; j >= 0; j--) begin
      if (lit_free[j]) first_idx = IDX_W'(j);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pol <= '0;
    end else if (bus.wr_i) begin
      pol <= bus.lit_pol_i;
    end
  end

  // Stage 1: registered clause status; a polarity load blanks it for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.wr_i) begin
      sat_r      <= 1'b0;
      cnt_r      <= 2'd0;
      unit_r     <= 1'b0;
      conflict_r <= 1'b0;
    end else begin
      sat_r      <= |lit_true;
      cnt_r      <= sat_cnt(free_cnt);
      unit_r     <= !(|lit_true) && (free_cnt == CNT_W'(1));
      conflict_r <= !(|lit_true) && (free_cnt == '0) && (|present);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx_r  <= '0;
      val_r  <= 2'b00;
      mask_r <= '0;
    end else begin
      state  <= state_nx;
      idx_r  <= idx_nx;
      val_r  <= val_nx;
      mask_r <= mask_nx;
    end
  end

  // Conflict reporting outranks implication when both are requested.
  always_comb begin
    state_nx = state;
    idx_nx   = idx_r;
    val_nx   = val_r;
    mask_nx  = mask_r;
    if (bus.wr_i) begin
      state_nx = IDLE;
      mask_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (conflict_r && bus.cclause_drv_i) begin
            mask_nx  = present;
            state_nx = CONFL;
          end else if (unit_r && bus.imp_drv_i) begin
            idx_nx   = first_idx;
            val_nx   = pol[2*int'(first_idx) +: 2];
            state_nx = IMPLY;
          end
        end
        IMPLY: if (bus.imp_ack_i) state_nx = IDLE;
        CONFL: begin
          if (!bus.cclause_drv_i) begin
            mask_nx  = '0;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.var_value_tobase_o = '0;
    if (state == IMPLY) bus.var_value_tobase_o[3*int'(idx_r) +: 3] = {1'b1, val_r};
  end

  assign bus.imp_valid_o  = (state == IMPLY);
  assign bus.cclause_o    = (state == CONFL) ? mask_r : '0;
  assign bus.clausesat_o  = sat_r;
  assign bus.freelitcnt_o = cnt_r;
  assign bus.unit_o       = unit_r;
  assign bus.conflict_o   = conflict_r;
endmodule

// File: tb/tb_clause_lits_n.sv
// Checks 2-, 8- and 16-literal clause slots side by side against a behavioural
// clause model: directed scenarios first, then randomized traffic.
module tb_clause_lits_n;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clause_lits_n_if #(.NUM_LITS(2))  b0 ();
  clause_lits_n_if #(.NUM_LITS(8))  b1 ();
  clause_lits_n_if #(.NUM_LITS(16)) b2 ();

  clause_lits_n #(.NUM_LITS(2))  u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  clause_lits_n #(.NUM_LITS(8))  u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  clause_lits_n #(.NUM_LITS(16)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int nl[3] = '{2, 8, 16};
  int hi[3] = '{1, 3, 15};

  logic [1:0] pol_in [3][16];
  logic [1:0] val_in [3][16];
  logic       xb     [3][16];
  logic       wr [3], idrv [3], ack [3], cdrv [3];

  logic [1:0]  m_pol  [3][16];
  logic        m_sat  [3], m_unit [3], m_conf [3];
  int          m_cnt  [3], m_mode [3], m_idx [3];
  logic [1:0]  m_val  [3];
  logic [15:0] m_mask [3];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply();
    for (int j = 0; j < 2; j++) begin
      b0.lit_pol_i[2*j +: 2] = pol_in[0][j];
      b0.var_value_frombase_i[3*j +: 3] = {xb[0][j], val_in[0][j]};
    end
    for (int j = 0; j < 8; j++) begin
      b1.lit_pol_i[2*j +: 2] = pol_in[1][j];
      b1.var_value_frombase_i[3*j +: 3] = {xb[1][j], val_in[1][j]};
    end
    for (int j = 0; j < 16; j++) begin
      b2.lit_pol_i[2*j +: 2] = pol_in[2][j];
      b2.var_value_frombase_i[3*j +: 3] = {xb[2][j], val_in[2][j]};
    end
    b0.wr_i = wr[0]; b0.imp_drv_i = idrv[0]; b0.imp_ack_i = ack[0]; b0.cclause_drv_i = cdrv[0];
    b1.wr_i = wr[1]; b1.imp_drv_i = idrv[1]; b1.imp_ack_i = ack[1]; b1.cclause_drv_i = cdrv[1];
    b2.wr_i = wr[2]; b2.imp_drv_i = idrv[2]; b2.imp_ack_i = ack[2]; b2.cclause_drv_i = cdrv[2];
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 16; j++) m_pol[k][j] = 2'b00;
      m_sat[k] = 0; m_unit[k] = 0; m_conf[k] = 0; m_cnt[k] = 0;
      m_mode[k] = 0; m_idx[k] = 0; m_val[k] = 0; m_mask[k] = 0;
    end
  endtask

  // Clause semantics at one rising edge, from the values presented before it.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      logic any_t, anyp;
      int raw, first;
      logic [15:0] pmask;
      any_t = 0; anyp = 0; raw = 0; first = -1; pmask = 0;
      for (int j = 0; j < nl[k]; j++) begin
        logic pr, tr, fr;
        pr = (m_pol[k][j] == 2'b01) || (m_pol[k][j] == 2'b10);
        tr = (m_pol[k][j] == 2'b01 && val_in[k][j] == 2'b01) ||
             (m_pol[k][j] == 2'b10 && val_in[k][j] == 2'b10);
        fr = pr && (val_in[k][j] == 2'b00 || val_in[k][j] == 2'b11);
        pmask[j] = pr;
        anyp  |= pr;
        any_t |= tr;
        if (fr) begin
          raw++;
          if (first < 0) first = j;
        end
      end
      if (wr[k]) begin
        for (int j = 0; j < 16; j++) m_pol[k][j] = pol_in[k][j];
        m_sat[k] = 0; m_unit[k] = 0; m_conf[k] = 0; m_cnt[k] = 0; m_mode[k] = 0;
      end else begin
        if (m_mode[k] == 0) begin
          if (m_conf[k] && cdrv[k]) begin
            m_mode[k] = 2;
            m_mask[k] = pmask;
          end else if (m_unit[k] && idrv[k]) begin
            m_mode[k] = 1;
            m_idx[k]  = (first < 0) ? 0 : first;
            m_val[k]  = m_pol[k][m_idx[k]];
          end
        end else if (m_mode[k] == 1) begin
          if (ack[k]) m_mode[k] = 0;
        end else begin
          if (!cdrv[k]) m_mode[k] = 0;
        end
        m_sat[k]  = any_t;
        m_cnt[k]  = (raw > 3) ? 3 : raw;
        m_unit[k] = !any_t && raw == 1;
        m_conf[k] = !any_t && raw == 0 && anyp;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [47:0] tob, tob_e;
      logic [15:0] cc, cc_e;
      logic [1:0]  cnt;
      logic        sat, unit, conf, iv;
      tob = '0; cc = '0;
      case (k)
        0: begin tob[5:0]  = b0.var_value_tobase_o; cc[1:0]  = b0.cclause_o; cnt = b0.freelitcnt_o;
                 sat = b0.clausesat_o; unit = b0.unit_o; conf = b0.conflict_o; iv = b0.imp_valid_o; end
        1: begin tob[23:0] = b1.var_value_tobase_o; cc[7:0]  = b1.cclause_o; cnt = b1.freelitcnt_o;
                 sat = b1.clausesat_o; unit = b1.unit_o; conf = b1.conflict_o; iv = b1.imp_valid_o; end
        default: begin tob = b2.var_value_tobase_o; cc = b2.cclause_o; cnt = b2.freelitcnt_o;
                 sat = b2.clausesat_o; unit = b2.unit_o; conf = b2.conflict_o; iv = b2.imp_valid_o; end
      endcase
      tob_e = '0;
      if (m_mode[k] == 1) tob_e[3*m_idx[k] +: 3] = {1'b1, m_val[k]};
      cc_e = (m_mode[k] == 2) ? m_mask[k] : 16'h0;
      chk($sformatf("n%0d_cnt", nl[k]),   64'(cnt),  64'(m_cnt[k]));
      chk($sformatf("n%0d_sat", nl[k]),   64'(sat),  64'(m_sat[k]));
      chk($sformatf("n%0d_unit", nl[k]),  64'(unit), 64'(m_unit[k]));
      chk($sformatf("n%0d_conf", nl[k]),  64'(conf), 64'(m_conf[k]));
      chk($sformatf("n%0d_ivld", nl[k]),  64'(iv),   64'(m_mode[k] == 1));
      chk($sformatf("n%0d_tobase", nl[k]), 64'(tob), 64'(tob_e));
      chk($sformatf("n%0d_cclause", nl[k]), 64'(cc), 64'(cc_e));
    end
  endtask

  task automatic step();
    apply();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_ctl();
    for (int k = 0; k < 3; k++) begin
      wr[k] = 0; idrv[k] = 0; ack[k] = 0; cdrv[k] = 0;
    end
  endtask

  // Clause (lit0 positive, lit hi negative), all values unassigned, loaded and settled.
  task automatic load_two_lit();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 16; j++) begin
        pol_in[k][j] = 2'b00; val_in[k][j] = 2'b00;
      end
      pol_in[k][0] = 2'b01;
      pol_in[k][hi[k]] = 2'b10;
      wr[k] = 1;
    end
    step();
    clear_ctl();
    step();
  endtask

  task automatic enter_imply();
    load_two_lit();
    for (int k = 0; k < 3; k++) val_in[k][0] = 2'b10;
    step();
    for (int k = 0; k < 3; k++) idrv[k] = 1;
    step();
    clear_ctl();
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 16; j++) begin
        pol_in[k][j] = 0; val_in[k][j] = 0; xb[k][j] = 0;
      end
    clear_ctl();
    apply();
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    load_two_lit();
    chk("n8_two_free", 64'(b1.freelitcnt_o), 64'd2);

    for (int k = 0; k < 3; k++) val_in[k][0] = 2'b10;
    step();
    chk("n8_unit", 64'(b1.unit_o), 64'd1);
    for (int k = 0; k < 3; k++) idrv[k] = 1;
    step();
    chk("n8_imp_field", 64'(b1.var_value_tobase_o), 64'(24'b110 << 9));
    chk("n2_imp_field", 64'(b0.var_value_tobase_o), 64'(6'b110_000));
    chk("n16_imp_field", 64'(b2.var_value_tobase_o), 64'({3'b110, 45'd0}));
    clear_ctl();
    step();
    for (int k = 0; k < 3; k++) ack[k] = 1;
    step();
    chk("n8_idle_after_ack", 64'(b1.imp_valid_o), 64'd0);
    clear_ctl();

    for (int k = 0; k < 3; k++) val_in[k][hi[k]] = 2'b01;
    step();
    chk("n8_conflict", 64'(b1.conflict_o), 64'd1);
    for (int k = 0; k < 3; k++) begin cdrv[k] = 1; idrv[k] = 1; end
    step();
    chk("n8_cmask", 64'(b1.cclause_o), 64'h09);
    chk("n8_no_imp_in_confl", 64'(b1.imp_valid_o), 64'd0);
    clear_ctl();
    step();
    chk("n8_cmask_clear", 64'(b1.cclause_o), 64'd0);

    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 16; j++) begin pol_in[k][j] = 2'b01; val_in[k][j] = 2'b00; xb[k][j] = 1; end
      wr[k] = 1;
    end
    step();
    clear_ctl();
    step();
    chk("n8_cnt_saturate", 64'(b1.freelitcnt_o), 64'd3);
    for (int k = 0; k < 3; k++) val_in[k][1] = 2'b01;
    step();
    chk("n8_sat", 64'(b1.clausesat_o), 64'd1);

    enter_imply();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 16; j++) pol_in[k][j] = 2'b01;
      wr[k] = 1;
    end
    step();
    chk("n8_wr_aborts_imply", 64'(b1.imp_valid_o), 64'd0);
    clear_ctl();
    step();

    enter_imply();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("n8_async_rst_drive", 64'(b1.var_value_tobase_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check_all();

    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        wr[k]   = ($urandom_range(15) == 0);
        idrv[k] = $urandom_range(1);
        ack[k]  = ($urandom_range(3) == 0);
        cdrv[k] = ($urandom_range(3) != 0);
        for (int j = 0; j < 16; j++) begin
          if (wr[k]) pol_in[k][j] = 2'($urandom_range(3));
          if ($urandom_range(7) == 0) val_in[k][j] = 2'($urandom_range(3));
          xb[k][j] = $urandom_range(1);
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
